// File: rtl/vga2_pkg.sv
// vga2_pkg: shared types and widths for the vga2 SDRAM arbiter
package vga2_pkg;
    typedef enum logic [2:0] {IDLE, CPU_REQ, CPU_WAIT, VGA_REQ, VGA_WAIT} arb_state_t;
    localparam int SDRAM_ADDR_W = 26;
endpackage

// File: rtl/vga2_sdram_arbiter.sv
// vga2_sdram_arbiter: two-master (VGA burst read, CPU read/write) arbiter in front of one SDRAM controller port
//  Ports: clock/reset (async, active-high); cpu_sdram_* CPU master; vga_sdram_* VGA master (read-only);
//  sdram_* the single controller port. One transaction outstanding; owner holds grant until sdram_complete.
//  VGA is favoured; after VGA_MAX_CONSEC back-to-back VGA grants with the CPU waiting, the CPU wins.
module vga2_sdram_arbiter
    import vga2_pkg::*;
#(
    parameter int ADDR_W         = SDRAM_ADDR_W,
    parameter int DATA_W         = 32,
    parameter int VGA_MAX_CONSEC = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_sdram_request,
    output logic              cpu_sdram_ready,
    input  logic              cpu_sdram_write,
    input  logic [ADDR_W-1:0] cpu_sdram_address,
    input  logic [DATA_W-1:0] cpu_sdram_wdata,
    input  logic [3:0]        cpu_sdram_wmask,
    output logic              cpu_sdram_rvalid,
    output logic [ADDR_W-1:0] cpu_sdram_raddress,
    output logic [DATA_W-1:0] cpu_sdram_rdata,
    output logic              cpu_sdram_complete,
    input  logic              vga_sdram_request,
    output logic              vga_sdram_ready,
    input  logic [ADDR_W-1:0] vga_sdram_address,
    output logic              vga_sdram_rvalid,
    output logic [ADDR_W-1:0] vga_sdram_raddress,
    output logic [DATA_W-1:0] vga_sdram_rdata,
    output logic              vga_sdram_complete,
    output logic              sdram_request,
    input  logic              sdram_ready,
    output logic              sdram_write,
    output logic [ADDR_W-1:0] sdram_address,
    output logic [DATA_W-1:0] sdram_wdata,
    output logic [3:0]        sdram_wmask,
    input  logic              sdram_rvalid,
    input  logic [ADDR_W-1:0] sdram_raddress,
    input  logic [DATA_W-1:0] sdram_rdata,
    input  logic              sdram_complete
);
    localparam logic [3:0] MAX_CONSEC = 4'(VGA_MAX_CONSEC);

    arb_state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    assign cpu_sdram_rdata    = sdram_rdata;
    assign cpu_sdram_raddress = sdram_raddress;
    assign vga_sdram_rdata    = sdram_rdata;
    assign vga_sdram_raddress = sdram_raddress;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The request line is driven by state, not by the master, so it can never drop before acceptance.
    always_comb begin
        state_d            = state_q;
        cnt_d              = cnt_q;
        sdram_request      = 1'b0;
        sdram_write        = 1'b0;
        sdram_address      = '0;
        sdram_wdata        = '0;
        sdram_wmask        = '0;
        cpu_sdram_ready    = 1'b0;
        cpu_sdram_rvalid   = 1'b0;
        cpu_sdram_complete = 1'b0;
        vga_sdram_ready    = 1'b0;
        vga_sdram_rvalid   = 1'b0;
        vga_sdram_complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (vga_sdram_request && !(cpu_sdram_request && cnt_q == MAX_CONSEC)) begin
                    state_d = VGA_REQ;
                    cnt_d   = !cpu_sdram_request ? '0 : (cnt_q == 4'hF ? cnt_q : cnt_q + 4'd1);
                end else if (cpu_sdram_request) begin
                    state_d = CPU_REQ;
                    cnt_d   = '0;
                end
            end
            CPU_REQ: begin
                sdram_request   = 1'b1;
                sdram_write     = cpu_sdram_write;
                sdram_address   = cpu_sdram_address;
                sdram_wdata     = cpu_sdram_wdata;
                sdram_wmask     = cpu_sdram_wmask;
                cpu_sdram_ready = sdram_ready;
                state_d         = sdram_ready ? CPU_WAIT : CPU_REQ;
            end
            CPU_WAIT: begin
                cpu_sdram_rvalid   = sdram_rvalid;
                cpu_sdram_complete = sdram_complete;
                state_d            = sdram_complete ? IDLE : CPU_WAIT;
            end
            VGA_REQ: begin
                sdram_request   = 1'b1;
                sdram_address   = vga_sdram_address;
                vga_sdram_ready = sdram_ready;
                state_d         = sdram_ready ? VGA_WAIT : VGA_REQ;
            end
            VGA_WAIT: begin
                vga_sdram_rvalid   = sdram_rvalid;
                vga_sdram_complete = sdram_complete;
                state_d            = sdram_complete ? IDLE : VGA_WAIT;
            end
            default: state_d = IDLE;
        endcase
    end

    a_cpu_hold: assert property (@(posedge clock) disable iff (reset) state_q == CPU_REQ |-> cpu_sdram_request);
    a_vga_hold: assert property (@(posedge clock) disable iff (reset) state_q == VGA_REQ |-> vga_sdram_request);
endmodule

// File: tb/tb_vga2_sdram_arbiter.sv
// tb_vga2_sdram_arbiter: directed table and sequence checks for vga2_sdram_arbiter
module tb_vga2_sdram_arbiter;
    localparam logic [25:0] CPU_A = 26'h0000040;
    localparam logic [25:0] VGA_A = 26'h0001000;
    localparam logic [31:0] WDATA = 32'hDEADBEEF;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_wr = 1'b0, vga_req = 1'b0;
    logic        cpu_ready, cpu_rvalid, cpu_cmp, vga_ready, vga_rvalid, vga_cmp;
    logic [25:0] cpu_raddr, vga_raddr, sd_addr;
    logic [31:0] cpu_rdata, vga_rdata, sd_wdata;
    logic [3:0]  sd_wmask;
    logic        sd_req, sd_wr;
    logic        sd_ready = 1'b0, sd_rvalid = 1'b0, sd_cmp = 1'b0;
    logic [25:0] sd_raddr = '0;
    logic [31:0] sd_rdata = '0;
    int          checks = 0, failures = 0;

    always #5 clock = ~clock;

    vga2_sdram_arbiter dut (
        .clock(clock), .reset(reset),
        .cpu_sdram_request(cpu_req), .cpu_sdram_ready(cpu_ready), .cpu_sdram_write(cpu_wr),
        .cpu_sdram_address(CPU_A), .cpu_sdram_wdata(WDATA), .cpu_sdram_wmask(4'hF),
        .cpu_sdram_rvalid(cpu_rvalid), .cpu_sdram_raddress(cpu_raddr), .cpu_sdram_rdata(cpu_rdata),
        .cpu_sdram_complete(cpu_cmp),
        .vga_sdram_request(vga_req), .vga_sdram_ready(vga_ready), .vga_sdram_address(VGA_A),
        .vga_sdram_rvalid(vga_rvalid), .vga_sdram_raddress(vga_raddr), .vga_sdram_rdata(vga_rdata),
        .vga_sdram_complete(vga_cmp),
        .sdram_request(sd_req), .sdram_ready(sd_ready), .sdram_write(sd_wr), .sdram_address(sd_addr),
        .sdram_wdata(sd_wdata), .sdram_wmask(sd_wmask), .sdram_rvalid(sd_rvalid),
        .sdram_raddress(sd_raddr), .sdram_rdata(sd_rdata), .sdram_complete(sd_cmp)
    );

    typedef struct {
        logic        cpu, wr, vga, rdy, rv, cmp;
        logic [7:0]  flags;
        logic [25:0] addr;
        logic        cpu_fields;
    } vec_t;

    vec_t tbl[18];

    function automatic logic [69:0] outs();
        return {sd_req, sd_wr, cpu_ready, vga_ready, cpu_rvalid, vga_rvalid, cpu_cmp, vga_cmp,
                sd_addr, sd_wdata, sd_wmask};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        cpu_req = 1'b0; vga_req = 1'b0; cpu_wr = 1'b0;
        sd_ready = 1'b0; sd_rvalid = 1'b0; sd_cmp = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_req();
        for (int k = 0; k < 20 && !sd_req; k++) begin
            @(negedge clock);
            #1;
        end
        chk("req_seen", 128'(sd_req), 128'(1'b1));
    endtask

    task automatic serve(output logic who);
        @(negedge clock);
        #1;
        wait_req();
        who = (sd_addr == CPU_A);
        sd_ready = 1'b1;
        #1;
        chk("serve_ready", 128'({cpu_ready, vga_ready}), 128'(who ? 2'b10 : 2'b01));
        @(negedge clock);
        sd_ready = 1'b0; sd_rvalid = 1'b1; sd_cmp = 1'b1;
        #1;
        chk("serve_deassert", 128'(sd_req), 128'(1'b0));
        chk("serve_resp", 128'({cpu_rvalid, vga_rvalid, cpu_cmp, vga_cmp}), 128'(who ? 4'b1010 : 4'b0101));
        @(negedge clock);
        sd_rvalid = 1'b0; sd_cmp = 1'b0;
        #1;
        chk("serve_idle_gap", 128'(sd_req), 128'(1'b0));
    endtask

    initial begin
        logic [9:0] order, exp_order;
        logic       who;
        int         bad, pulses;
        tbl[0]  = '{0, 0, 1, 0, 0, 0, 8'b00000000, 26'h0,  0};
        tbl[1]  = '{0, 0, 1, 0, 0, 0, 8'b10000000, VGA_A,  0};
        tbl[2]  = '{0, 0, 1, 1, 0, 0, 8'b10010000, VGA_A,  0};
        tbl[3]  = '{0, 0, 0, 0, 1, 0, 8'b00000100, 26'h0,  0};
        tbl[4]  = '{0, 0, 0, 0, 1, 1, 8'b00000101, 26'h0,  0};
        tbl[5]  = '{0, 0, 0, 0, 1, 1, 8'b00000000, 26'h0,  0};
        tbl[6]  = '{1, 1, 0, 0, 0, 0, 8'b00000000, 26'h0,  0};
        tbl[7]  = '{1, 1, 0, 0, 1, 0, 8'b11000000, CPU_A,  1};
        tbl[8]  = '{1, 1, 0, 1, 0, 0, 8'b11100000, CPU_A,  1};
        tbl[9]  = '{0, 0, 0, 0, 0, 1, 8'b00000010, 26'h0,  0};
        tbl[10] = '{1, 0, 1, 0, 0, 0, 8'b00000000, 26'h0,  0};
        tbl[11] = '{1, 0, 1, 1, 0, 0, 8'b10010000, VGA_A,  0};
        tbl[12] = '{1, 0, 0, 0, 1, 1, 8'b00000101, 26'h0,  0};
        tbl[13] = '{1, 0, 0, 0, 0, 0, 8'b00000000, 26'h0,  0};
        tbl[14] = '{1, 0, 0, 1, 0, 0, 8'b10100000, CPU_A,  1};
        tbl[15] = '{0, 0, 0, 0, 1, 0, 8'b00001000, 26'h0,  0};
        tbl[16] = '{0, 0, 0, 0, 0, 1, 8'b00000010, 26'h0,  0};
        tbl[17] = '{0, 0, 0, 0, 0, 0, 8'b00000000, 26'h0,  0};

        sd_rvalid = 1'b1; sd_cmp = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        chk("reset_state", 128'(outs()), 128'(0));
        sd_rvalid = 1'b0; sd_cmp = 1'b0;
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            @(negedge clock);
            cpu_req = tbl[i].cpu; cpu_wr = tbl[i].wr; vga_req = tbl[i].vga;
            sd_ready = tbl[i].rdy; sd_rvalid = tbl[i].rv; sd_cmp = tbl[i].cmp;
            sd_rdata = 32'hA5000000 | 32'(i); sd_raddr = 26'(i * 4);
            #1;
            chk($sformatf("vec%0d", i), 128'(outs()),
                128'({tbl[i].flags, tbl[i].addr, tbl[i].cpu_fields ? WDATA : 32'h0,
                      tbl[i].cpu_fields ? 4'hF : 4'h0}));
            chk($sformatf("bcast%0d", i), 128'({cpu_rdata, vga_rdata, cpu_raddr, vga_raddr}),
                128'({sd_rdata, sd_rdata, sd_raddr, sd_raddr}));
        end

        do_reset();
        cpu_req = 1'b1; vga_req = 1'b1;
        exp_order = 10'b0000100001;
        order = '0;
        for (int g = 0; g < 10; g++) begin
            serve(who);
            order[9-g] = who;
            chk($sformatf("grant%0d", g), 128'(who), 128'(exp_order[9-g]));
        end
        cpu_req = 1'b0; vga_req = 1'b0;
        chk("grant_order", 128'(order), 128'(exp_order));

        do_reset();
        vga_req = 1'b1;
        @(negedge clock);
        #1;
        wait_req();
        sd_ready = 1'b1;
        @(negedge clock);
        sd_ready = 1'b0; vga_req = 1'b0;
        for (int w = 0; w < 3; w++) begin
            sd_rvalid = 1'b1;
            #1;
            chk($sformatf("mid_word%0d", w), 128'({vga_rvalid, cpu_rvalid}), 128'(2'b10));
            @(negedge clock);
        end
        reset = 1'b1;
        #1;
        chk("reset_mid_outs", 128'(outs()), 128'(0));
        @(negedge clock);
        reset = 1'b0;
        bad = 0;
        for (int w = 3; w < 8; w++) begin
            sd_rvalid = 1'b1; sd_cmp = (w == 7);
            #1;
            bad += int'({cpu_rvalid, vga_rvalid, cpu_cmp, vga_cmp} != 4'b0) + int'(sd_req);
            @(negedge clock);
        end
        sd_rvalid = 1'b0; sd_cmp = 1'b0;
        chk("stray_dropped", 128'(bad), 128'(0));

        do_reset();
        cpu_req = 1'b1; cpu_wr = 1'b1;
        @(negedge clock);
        #1;
        wait_req();
        bad = 0; pulses = 0;
        for (int c = 0; c < 20; c++) begin
            bad += int'({sd_req, sd_wr, sd_addr, sd_wdata, sd_wmask} != {1'b1, 1'b1, CPU_A, WDATA, 4'hF});
            pulses += int'(cpu_ready);
            @(negedge clock);
            #1;
        end
        chk("ready_low_stable", 128'(bad), 128'(0));
        sd_ready = 1'b1;
        #1;
        pulses += int'(cpu_ready);
        @(negedge clock);
        sd_ready = 1'b0; cpu_req = 1'b0; cpu_wr = 1'b0;
        #1;
        pulses += int'(cpu_ready);
        chk("ready_pulses", 128'(pulses), 128'(1));
        sd_cmp = 1'b1;
        #1;
        chk("cpu_complete", 128'({cpu_cmp, vga_cmp}), 128'(2'b10));
        @(negedge clock);
        sd_cmp = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
